// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osc_pkg
// Purpose  : Shared types and constants for the scope capture path.
// Contents : cap_state_t - capture FSM states
//            CAP_DEPTH   - default record length in samples
//            CAP_ADDR_W  - default record address width
//            sample_t    - one filtered 8-bit sample
// Revision : 1.0 - initial release
// ============================================================================
package osc_pkg;

  localparam int CAP_DEPTH  = 256;
  localparam int CAP_ADDR_W = 8;

  typedef logic [7:0] sample_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE_FILL  = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4,
    READ      = 3'd5
  } cap_state_t;

endpackage : osc_pkg
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
// Module   : capture_ram
// Purpose  : Simple dual-port DEPTH x 8 sample store, one write port and one
//            registered read port (read data valid one cycle after re_i).
// Ports    : clk     - system clock
//            rst     - synchronous active-high reset (read register only)
//            we_i    - write enable
//            waddr_i - write address
//            wdata_i - write data
//            re_i    - read enable
//            raddr_i - read address
//            rdata_o - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module capture_ram
  import osc_pkg::*;
#(
  parameter int DEPTH  = CAP_DEPTH,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  sample_t           wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output sample_t           rdata_o
);

  // Array carries no reset so it can map onto block RAM.
  sample_t mem_q [DEPTH];
  sample_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register reset matches the block RAM output-latch reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : capture_ram
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture
// Purpose  : Stores a DEPTH-sample record around a level/edge trigger with
//            PRE_NUM samples of pre-trigger history, then replays the record
//            in chronological order over an rd_en/rd_vld handshake.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            din, din_vld           - filtered sample stream
//            arm                    - start an acquisition (IDLE or DONE)
//            trig_level, trig_edge  - trigger setup, latched on accepted arm
//            force_trig             - trigger on next valid sample
//            busy, trig_seen, done  - acquisition status
//            rd_en                  - request one record sample
//            rd_data, rd_vld, rd_last - read response (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module trigger_capture
  import osc_pkg::*;
#(
  parameter int DEPTH   = CAP_DEPTH,
  parameter int ADDR_W  = CAP_ADDR_W,
  parameter int PRE_NUM = 64
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t din,
  input  logic    din_vld,
  input  logic    arm,
  input  sample_t trig_level,
  input  logic    trig_edge,
  input  logic    force_trig,
  output logic    busy,
  output logic    trig_seen,
  output logic    done,
  input  logic    rd_en,
  output sample_t rd_data,
  output logic    rd_vld,
  output logic    rd_last
);

  localparam logic [ADDR_W-1:0] c_PRE_NUM   = ADDR_W'(PRE_NUM);
  localparam logic [ADDR_W-1:0] c_PRE_LAST  = ADDR_W'(PRE_NUM - 1);
  localparam logic [ADDR_W-1:0] c_POST_LAST = ADDR_W'(DEPTH - PRE_NUM - 2);
  localparam logic [ADDR_W:0]   c_RD_TOTAL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_RD_LAST   = (ADDR_W+1)'(DEPTH - 1);

  cap_state_t        state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W:0]   rd_cnt_q;
  sample_t           prev_q;
  sample_t           level_q;
  logic              edge_q;
  logic              force_q;
  logic              busy_q;
  logic              trig_seen_q;
  logic              done_q;
  logic              rd_vld_q;
  logic              rd_last_q;

  logic              wr_en;
  logic              hit;
  logic              trig_fire;
  logic              arm_ok;
  logic              rd_start;
  logic              rd_issue;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    wr_en     = din_vld && (state_q == PRE_FILL || state_q == WAIT_TRIG ||
                            state_q == POST);
    hit       = edge_q ? (prev_q > level_q && din <= level_q)
                       : (prev_q < level_q && din >= level_q);
    trig_fire = (state_q == WAIT_TRIG) && din_vld && (hit || force_q);
    arm_ok    = arm && (state_q == IDLE || state_q == DONE);
    // arm wins over rd_en while in DONE.
    rd_start  = (state_q == DONE) && rd_en && !arm;
    rd_issue  = rd_start || ((state_q == READ) && rd_en && (rd_cnt_q != c_RD_TOTAL));
    rd_addr   = rd_start ? start_q : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_q     <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      prev_q      <= '0;
      level_q     <= '0;
      edge_q      <= 1'b0;
      force_q     <= 1'b0;
      busy_q      <= 1'b0;
      trig_seen_q <= 1'b0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      rd_vld_q  <= rd_issue;
      rd_last_q <= rd_issue && (rd_cnt_q == c_RD_LAST);

      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        prev_q   <= din;
      end

      if (rd_issue) begin
        rd_ptr_q <= rd_addr + 1'b1;
        rd_cnt_q <= rd_start ? (ADDR_W+1)'(1) : rd_cnt_q + 1'b1;
      end

      if (arm_ok) begin
        level_q     <= trig_level;
        edge_q      <= trig_edge;
        wr_ptr_q    <= '0;
        cnt_q       <= '0;
        force_q     <= 1'b0;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        trig_seen_q <= 1'b0;
        state_q     <= PRE_FILL;
      end else begin
        case (state_q)
          PRE_FILL: begin
            if (din_vld) begin
              if (cnt_q == c_PRE_LAST) begin
                cnt_q   <= '0;
                state_q <= WAIT_TRIG;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          WAIT_TRIG: begin
            if (force_trig) begin
              force_q <= 1'b1;
            end
            if (trig_fire) begin
              // The trigger sample lands at wr_ptr_q; history starts PRE_NUM back.
              start_q     <= wr_ptr_q - c_PRE_NUM;
              trig_seen_q <= 1'b1;
              force_q     <= 1'b0;
              cnt_q       <= '0;
              state_q     <= POST;
            end
          end
          POST: begin
            if (din_vld) begin
              if (cnt_q == c_POST_LAST) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          DONE: begin
            if (rd_en) begin
              state_q <= READ;
            end
          end
          READ: begin
            // rd_last is on the output this cycle, so the record is fully delivered.
            if (rd_last_q) begin
              done_q      <= 1'b0;
              trig_seen_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .re_i    (rd_issue),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign busy      = busy_q;
  assign trig_seen = trig_seen_q;
  assign done      = done_q;
  assign rd_vld    = rd_vld_q;
  assign rd_last   = rd_last_q;

endmodule : trigger_capture
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture
// Purpose  : Self-checking bench for trigger_capture. Capture scenarios come
//            from a vector table; readout data is checked through a queue of
//            expected samples pushed on every rd_en and popped on rd_vld.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;
  import osc_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  sample_t din;
  logic    din_vld;
  logic    arm;
  sample_t trig_level;
  logic    trig_edge;
  logic    force_trig;
  logic    busy;
  logic    trig_seen;
  logic    done;
  logic    rd_en;
  sample_t rd_data;
  logic    rd_vld;
  logic    rd_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_capture #(
    .DEPTH   (256),
    .ADDR_W  (8),
    .PRE_NUM (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_vld    (din_vld),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .force_trig (force_trig),
    .busy       (busy),
    .trig_seen  (trig_seen),
    .done       (done),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
    .rd_last    (rd_last)
  );

  // mode: 0 ramp, 1 falling step 200x70/40/30..., 2 constant 10 with force
  typedef struct {
    bit      edge_sel;
    sample_t level;
    int      mode;
    bit      vld_tog;
    bit      rd_tog;
    int      trig_at;   // index of trigger sample among valid samples since arm
    int      exp_busy;  // cycles with busy high
    sample_t e0;
    sample_t e63;
    sample_t e64;
    sample_t e255;
  } vec_t;

  typedef struct {
    sample_t data;
    int      idx;
    int      due;
  } sb_t;

  vec_t    vecs[4];
  sb_t     sbq[$];
  sample_t hist[$];
  sample_t exp_rec[256];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic sample_t gen(input int mode, input int n);
    if (mode == 0) return sample_t'(n % 256);
    if (mode == 1) return (n < 70) ? 8'd200 : ((n == 70) ? 8'd40 : 8'd30);
    return 8'd10;
  endfunction

  task automatic run_capture(input vec_t v, input string tag);
    int n = 0;
    int it = 0;
    int busy_cnt = 0;
    int rise_at = -1;
    bit forced = 0;
    bit pf_forced = 0;
    hist.delete();
    trig_level = v.level;
    trig_edge  = v.edge_sel;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    // Setup changes after arm must not matter.
    trig_level = ~v.level;
    trig_edge  = ~v.edge_sel;
    check($sformatf("%s busy_after_arm", tag), busy, 1);
    if (busy) busy_cnt++;
    while (!done && it < 2000) begin
      din_vld = 1'b0;
      force_trig = 1'b0;
      din = 8'hFF;
      if (v.mode == 2 && n == 10 && !pf_forced) begin
        force_trig = 1'b1;
        pf_forced = 1;
      end else if (v.mode == 2 && n == 300 && !forced) begin
        force_trig = 1'b1;
        forced = 1;
      end else if (v.vld_tog && (it % 2 == 0)) begin
        din_vld = 1'b0;
      end else begin
        din_vld = 1'b1;
        din = gen(v.mode, n);
        hist.push_back(din);
        n++;
      end
      tick();
      it++;
      if (busy) busy_cnt++;
      if (trig_seen && rise_at < 0) rise_at = n;
    end
    din_vld = 1'b0;
    force_trig = 1'b0;
    check($sformatf("%s done", tag), done, 1);
    check($sformatf("%s busy_at_done", tag), busy, 0);
    check($sformatf("%s trig_seen_at_done", tag), trig_seen, 1);
    check($sformatf("%s busy_cycles", tag), busy_cnt, v.exp_busy);
    check($sformatf("%s trig_seen_rise", tag), rise_at, v.trig_at + 1);
    check($sformatf("%s writes_to_done", tag), hist.size(), v.trig_at + 192);
    for (int k = 0; k < 256; k++) begin
      int idx;
      idx = v.trig_at - 64 + k;
      exp_rec[k] = (idx >= 0 && idx < hist.size()) ? hist[idx] : 8'h00;
    end
  endtask

  task automatic read_out(input vec_t v, input string tag);
    int issued = 0;
    int pulses = 0;
    int iters;
    sb_t e;
    iters = v.rd_tog ? 600 : 300;
    sbq.delete();
    for (int it = 0; it < iters; it++) begin
      rd_en = v.rd_tog ? (it % 2 == 0) : 1'b1;
      arm = (it == 100);
      if (rd_en && issued < 256) begin
        sbq.push_back('{exp_rec[issued], issued, it});
        issued++;
      end
      tick();
      arm = 1'b0;
      if (rd_vld) begin
        pulses++;
        if (sbq.size() == 0) begin
          check($sformatf("%s extra_rd_vld it=%0d", tag, it), rd_vld, 0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("%s rd_data[%0d]", tag, e.idx), rd_data, e.data);
          check($sformatf("%s rd_latency[%0d]", tag, e.idx), it, e.due);
          check($sformatf("%s rd_last[%0d]", tag, e.idx), rd_last, (e.idx == 255));
          if (e.idx == 0)   check($sformatf("%s idx0", tag), rd_data, v.e0);
          if (e.idx == 63)  check($sformatf("%s idx63", tag), rd_data, v.e63);
          if (e.idx == 64)  check($sformatf("%s idx64", tag), rd_data, v.e64);
          if (e.idx == 255) begin
            check($sformatf("%s idx255", tag), rd_data, v.e255);
            check($sformatf("%s done_with_last", tag), done, 1);
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due == it) begin
        check($sformatf("%s missing_rd_vld[%0d]", tag, sbq[0].idx), rd_vld, 1);
        void'(sbq.pop_front());
      end
      if (it == 100) check($sformatf("%s arm_in_read_ignored", tag), busy, 0);
    end
    rd_en = 1'b0;
    check($sformatf("%s rd_vld_pulses", tag), pulses, 256);
    check($sformatf("%s done_after_read", tag), done, 0);
    check($sformatf("%s trig_seen_after_read", tag), trig_seen, 0);
    check($sformatf("%s pending_reads", tag), sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    din = '0;
    din_vld = 1'b0;
    arm = 1'b0;
    trig_level = '0;
    trig_edge = 1'b0;
    force_trig = 1'b0;
    rd_en = 1'b0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset trig_seen", trig_seen, 0);
    check("reset done", done, 0);
    check("reset rd_vld", rd_vld, 0);
    check("reset rd_last", rd_last, 0);
    check("reset rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{1'b0, 8'd100, 0, 1'b0, 1'b0, 100, 292, 8'd36,  8'd99,  8'd100, 8'd35};
    vecs[1] = '{1'b1, 8'd50,  1, 1'b0, 1'b0, 70,  262, 8'd200, 8'd200, 8'd40,  8'd30};
    vecs[2] = '{1'b0, 8'd100, 2, 1'b0, 1'b0, 300, 494, 8'd10,  8'd10,  8'd10,  8'd10};
    vecs[3] = '{1'b0, 8'd100, 0, 1'b1, 1'b1, 100, 584, 8'd36,  8'd99,  8'd100, 8'd35};

    for (int i = 0; i < 4; i++) begin
      run_capture(vecs[i], $sformatf("vec%0d", i));
      read_out(vecs[i], $sformatf("vec%0d", i));
    end

    // arm and rd_en together in DONE: arm wins, no read is issued.
    run_capture(vecs[0], "prio");
    arm = 1'b1;
    rd_en = 1'b1;
    trig_level = 8'd100;
    trig_edge = 1'b0;
    tick();
    arm = 1'b0;
    rd_en = 1'b0;
    check("prio rd_vld", rd_vld, 0);
    check("prio busy", busy, 1);
    check("prio done", done, 0);

    // Drive the restarted capture into POST, then reset it.
    n = 0;
    for (int it = 0; it < 1000 && !trig_seen; it++) begin
      din_vld = 1'b1;
      din = gen(0, n);
      n++;
      tick();
    end
    check("post trig_seen_before_reset", trig_seen, 1);
    repeat (10) begin
      din = gen(0, n);
      n++;
      tick();
    end
    din_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst busy", busy, 0);
    check("post_rst trig_seen", trig_seen, 0);
    check("post_rst done", done, 0);
    check("post_rst rd_vld", rd_vld, 0);
    tick();

    run_capture(vecs[0], "after_rst");
    read_out(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_trigger_capture
`default_nettype wire
